// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: groups the instruction-memory request bus and the
// fetch-to-decode instruction handoff into one bundle.
//   imem_req/imem_addr     fetch request and word-aligned address (fetch -> memory)
//   imem_ack/imem_rdata    data return strobe and instruction word (memory -> fetch)
//   ir/ir_pc/ir_valid      fetched instruction, its address, valid (fetch -> decode)
//   ir_ready               decode accepts ir this cycle (decode -> fetch)
// The master modport is the fetch unit; the slave modport is the environment
// (memory plus decoder) on the other side.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;

  modport master (
    output imem_req, imem_addr, ir, ir_pc, ir_valid,
    input  imem_ack, imem_rdata, ir_ready
  );

  modport slave (
    input  imem_req, imem_addr, ir, ir_pc, ir_valid,
    output imem_ack, imem_rdata, ir_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage. Holds the fetch PC, requests one word
// at a time from instruction memory and hands each word with its PC to decode.
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          ifetch_unit_if.master (imem req/ack bus + ir valid/ready handoff)
//   redirect     load redirect_pc as the next fetch address, drop current word
//   redirect_pc  new fetch address, bits [1:0] forced to zero
//   halt         stop fetching once any outstanding request completes
// Every output comes straight from a register, so no input reaches an output
// in the same cycle.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  ifetch_unit_if.master      bus,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               halt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    FULL  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t      state_r;
  logic [31:0] fetch_pc_r;
  logic [31:0] pending_pc_r;  // redirect target parked until the old request drains
  logic        halt_pend_r;   // halt seen while a request was outstanding
  logic [31:0] ir_r;
  logic [31:0] ir_pc_r;
  logic        ir_valid_r;
  logic        imem_req_r;

  logic [31:0] target_s;
  logic [31:0] next_pc_s;

  assign target_s  = redirect_pc & 32'hFFFF_FFFC;
  assign next_pc_s = fetch_pc_r + 32'd4;  // wraps modulo 2^32

  assign bus.imem_req  = imem_req_r;
  assign bus.imem_addr = fetch_pc_r;
  assign bus.ir        = ir_r;
  assign bus.ir_pc     = ir_pc_r;
  assign bus.ir_valid  = ir_valid_r;

  // Fetch state machine with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      fetch_pc_r   <= RESET_PC;
      pending_pc_r <= RESET_PC;
      halt_pend_r  <= 1'b0;
      ir_r         <= 32'd0;
      ir_pc_r      <= 32'd0;
      ir_valid_r   <= 1'b0;
      imem_req_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (halt) begin
            state_r    <= HALT;
            imem_req_r <= 1'b0;
            ir_valid_r <= 1'b0;
          end else if (redirect) begin
            fetch_pc_r <= target_s;
            state_r    <= REQ;
            imem_req_r <= 1'b1;
          end else begin
            state_r    <= REQ;
            imem_req_r <= 1'b1;
          end
        end

        REQ: begin
          if (halt || halt_pend_r) begin
            // Halt beats redirect; the in-flight word is dropped on ack.
            if (bus.imem_ack) begin
              state_r     <= HALT;
              imem_req_r  <= 1'b0;
              halt_pend_r <= 1'b0;
            end else begin
              halt_pend_r <= 1'b1;
            end
          end else if (redirect) begin
            if (bus.imem_ack) begin
              // Returned word belongs to the old path: drop it, refetch at target.
              fetch_pc_r <= target_s;
            end else begin
              // Address must stay on the old word until memory answers.
              pending_pc_r <= target_s;
              state_r      <= DRAIN;
            end
          end else if (bus.imem_ack) begin
            ir_r       <= bus.imem_rdata;
            ir_pc_r    <= fetch_pc_r;
            ir_valid_r <= 1'b1;
            fetch_pc_r <= next_pc_s;
            state_r    <= FULL;
            imem_req_r <= 1'b0;
          end else begin
            state_r <= REQ;
          end
        end

        FULL: begin
          if (halt) begin
            state_r    <= HALT;
            ir_valid_r <= 1'b0;
          end else if (redirect) begin
            // Drop the held word even if decode is ready this cycle.
            fetch_pc_r <= target_s;
            ir_valid_r <= 1'b0;
            state_r    <= REQ;
            imem_req_r <= 1'b1;
          end else if (bus.ir_ready) begin
            ir_valid_r <= 1'b0;
            state_r    <= REQ;
            imem_req_r <= 1'b1;
          end else begin
            state_r <= FULL;
          end
        end

        DRAIN: begin
          if (bus.imem_ack) begin
            // A redirect landing on the ack cycle is the newest target.
            if (redirect && !halt) begin
              fetch_pc_r <= target_s;
            end else begin
              fetch_pc_r <= pending_pc_r;
            end
            if (halt || halt_pend_r) begin
              state_r     <= HALT;
              imem_req_r  <= 1'b0;
              halt_pend_r <= 1'b0;
            end else begin
              state_r <= REQ;
            end
          end else if (halt) begin
            halt_pend_r <= 1'b1;
          end else if (redirect) begin
            pending_pc_r <= target_s;
          end else begin
            state_r <= DRAIN;
          end
        end

        HALT: begin
          if (redirect && !halt) begin
            fetch_pc_r <= target_s;
            state_r    <= REQ;
            imem_req_r <= 1'b1;
          end else begin
            state_r <= HALT;
          end
        end

        default: begin
          state_r     <= IDLE;
          imem_req_r  <= 1'b0;
          ir_valid_r  <= 1'b0;
          halt_pend_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
